// File: rtl/freq_meas_core.sv
// freq_meas_core: gated rising-edge counter behind the freq_meas register bank.
// Counts synchronised sig_in edges over a programmable window of ACLK cycles.
module freq_meas_core #(
    parameter int CNT_WIDTH   = 32,
    parameter int GATE_WIDTH  = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  en,
    input  logic                  continuous,
    input  logic                  start,
    input  logic [GATE_WIDTH-1:0] gate_len,
    input  logic                  sig_in,
    output logic [CNT_WIDTH-1:0]  edge_count,
    output logic                  count_valid,
    output logic                  overflow,
    output logic                  busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GATE = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [GATE_WIDTH-1:0] GATE_ONE = GATE_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = '1;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    w_load;
    logic                    w_publish;
    logic                    w_len_nz;

    logic [SYNC_STAGES-1:0]  r_sync;
    logic                    r_prev;
    logic                    w_rise;

    logic [GATE_WIDTH-1:0]   r_gate_len;
    logic [GATE_WIDTH-1:0]   r_timer;
    logic [CNT_WIDTH-1:0]    r_cnt;
    logic                    r_ovf;
    logic [CNT_WIDTH-1:0]    w_cnt_nxt;
    logic                    w_ovf_nxt;

    logic [CNT_WIDTH-1:0]    r_edge_count;
    logic                    r_overflow;
    logic                    r_count_valid;

    assign w_len_nz = (gate_len != '0);
    assign w_rise   = r_sync[SYNC_STAGES-1] & ~r_prev;

    // Saturating count including this cycle's edge; overflow is sticky.
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_ovf_nxt = r_ovf;
        if (w_rise) begin
            if (r_cnt == CNT_MAX) begin
                w_ovf_nxt = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt + CNT_ONE;
            end
        end
    end

    // Synchroniser chain and edge-detect flop, free-running in every state.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    // FSM state register.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, gate load and result publish decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_publish   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (en && start && w_len_nz) begin
                    w_state_nxt = S_GATE;
                    w_load      = 1'b1;
                end
            end
            S_GATE: begin
                if (!en) begin
                    w_state_nxt = S_IDLE;
                end else if (r_timer == r_gate_len) begin
                    w_state_nxt = S_DONE;
                    w_publish   = 1'b1;
                end
            end
            S_DONE: begin
                if (en && continuous && w_len_nz) begin
                    w_state_nxt = S_GATE;
                    w_load      = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Gate timer, running count and the published result registers.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_gate_len    <= '0;
            r_timer       <= '0;
            r_cnt         <= '0;
            r_ovf         <= 1'b0;
            r_edge_count  <= '0;
            r_overflow    <= 1'b0;
            r_count_valid <= 1'b0;
        end else begin
            r_count_valid <= w_publish;
            if (w_load) begin
                r_gate_len <= gate_len;
                r_timer    <= GATE_ONE;
                r_cnt      <= '0;
                r_ovf      <= 1'b0;
            end else if (r_state == S_GATE) begin
                r_timer <= r_timer + GATE_ONE;
                r_cnt   <= w_cnt_nxt;
                r_ovf   <= w_ovf_nxt;
            end
            if (w_publish) begin
                r_edge_count <= w_cnt_nxt;
                r_overflow   <= w_ovf_nxt;
            end
        end
    end

    assign edge_count  = r_edge_count;
    assign overflow    = r_overflow;
    assign count_valid = r_count_valid;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_freq_meas_core.sv
// tb_freq_meas_core: scoreboard bench for freq_meas_core.
// Runs a 32-bit and an 8-bit counter instance from the same stimulus.
module tb_freq_meas_core;

    typedef struct {
        logic [31:0] cnt;
        logic        ovf;
    } exp_t;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        en = 1'b0;
    logic        continuous = 1'b0;
    logic        start = 1'b0;
    logic [31:0] gate_len = '0;
    logic        sig_in = 1'b0;

    logic [31:0] edge_count;
    logic        count_valid;
    logic        overflow;
    logic        busy;

    logic [7:0]  edge_count8;
    logic        count_valid8;
    logic        overflow8;
    logic        busy8;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int valid_cnt = 0;
    int last_valid_cyc = 0;
    int start_cyc = 0;
    int sig_period = 0;
    int ph = 0;

    exp_t q32[$];
    exp_t q8[$];

    freq_meas_core #(
        .CNT_WIDTH(32), .GATE_WIDTH(32), .SYNC_STAGES(2)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET), .en(en),
        .continuous(continuous), .start(start),
        .gate_len(gate_len), .sig_in(sig_in),
        .edge_count(edge_count), .count_valid(count_valid),
        .overflow(overflow), .busy(busy)
    );

    freq_meas_core #(
        .CNT_WIDTH(8), .GATE_WIDTH(32), .SYNC_STAGES(2)
    ) dut8 (
        .ACLK(ACLK), .ARESET(ARESET), .en(en),
        .continuous(continuous), .start(start),
        .gate_len(gate_len), .sig_in(sig_in),
        .edge_count(edge_count8), .count_valid(count_valid8),
        .overflow(overflow8), .busy(busy8)
    );

    always #5 ACLK = ~ACLK;

    // Cycle counter: value N after the Nth rising edge.
    always @(posedge ACLK) cyc = cyc + 1;

    // ACLK-synchronous square wave, high for the first half of each period.
    always @(posedge ACLK) begin
        #1;
        if (sig_period < 2) begin
            sig_in = 1'b0;
        end else begin
            ph = (ph + 1 >= sig_period) ? 0 : ph + 1;
            sig_in = (ph < sig_period / 2);
        end
    end

    // Scoreboard consumer for the 32-bit instance.
    always @(negedge ACLK) begin
        if (count_valid) begin
            exp_t e;
            valid_cnt = valid_cnt + 1;
            last_valid_cyc = cyc;
            vectors = vectors + 1;
            if (q32.size() == 0) begin
                miscompares = miscompares + 1;
                $display("FAIL unexpected_valid32 cyc=%0d count=%0d", cyc, edge_count);
            end else begin
                e = q32.pop_front();
                if (edge_count !== e.cnt || overflow !== e.ovf) begin
                    miscompares = miscompares + 1;
                    $display("FAIL result32 got cnt=%0d ovf=%b want cnt=%0d ovf=%b",
                             edge_count, overflow, e.cnt, e.ovf);
                end
            end
        end
    end

    // Scoreboard consumer for the 8-bit instance.
    always @(negedge ACLK) begin
        if (count_valid8) begin
            exp_t e;
            vectors = vectors + 1;
            if (q8.size() == 0) begin
                miscompares = miscompares + 1;
                $display("FAIL unexpected_valid8 cyc=%0d count=%0d", cyc, edge_count8);
            end else begin
                e = q8.pop_front();
                if (edge_count8 !== e.cnt[7:0] || overflow8 !== e.ovf) begin
                    miscompares = miscompares + 1;
                    $display("FAIL result8 got cnt=%0d ovf=%b want cnt=%0d ovf=%b",
                             edge_count8, overflow8, e.cnt[7:0], e.ovf);
                end
            end
        end
    end

    task automatic push_both(input logic [31:0] c32, input logic o32,
                             input logic [31:0] c8, input logic o8);
        exp_t a;
        exp_t b;
        a.cnt = c32;
        a.ovf = o32;
        b.cnt = c8;
        b.ovf = o8;
        q32.push_back(a);
        q8.push_back(b);
    endtask

    task automatic pulse_start(input logic [31:0] len);
        @(posedge ACLK);
        #1;
        gate_len = len;
        start = 1'b1;
        start_cyc = cyc + 1;
        @(posedge ACLK);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_valid(input int target, input int budget);
        int n;
        n = 0;
        while (valid_cnt < target && n < budget) begin
            @(posedge ACLK);
            n = n + 1;
        end
        #1;
        if (valid_cnt < target) begin
            vectors = vectors + 1;
            miscompares = miscompares + 1;
            $display("FAIL wait_valid timeout got=%0d want=%0d", valid_cnt, target);
        end
    endtask

    task automatic test_reset;
        ARESET = 1'b1;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        vectors = vectors + 1;
        if ({edge_count, overflow, count_valid, busy} !== 35'd0) begin
            miscompares = miscompares + 1;
            $display("FAIL reset32 got cnt=%0d ovf=%b vld=%b busy=%b want 0",
                     edge_count, overflow, count_valid, busy);
        end
        vectors = vectors + 1;
        if ({edge_count8, overflow8, count_valid8, busy8} !== 11'd0) begin
            miscompares = miscompares + 1;
            $display("FAIL reset8 got cnt=%0d ovf=%b vld=%b busy=%b want 0",
                     edge_count8, overflow8, count_valid8, busy8);
        end
        ARESET = 1'b0;
        en = 1'b1;
        sig_period = 10;
        repeat (10) @(posedge ACLK);
    endtask

    task automatic test_basic;
        int v0;
        v0 = valid_cnt;
        push_both(32'd100, 1'b0, 32'd100, 1'b0);
        pulse_start(32'd1000);
        vectors = vectors + 1;
        if (busy !== 1'b1) begin
            miscompares = miscompares + 1;
            $display("FAIL basic_busy got=%b want=1", busy);
        end
        wait_valid(v0 + 1, 1100);
        vectors = vectors + 1;
        if (last_valid_cyc !== start_cyc + 1000) begin
            miscompares = miscompares + 1;
            $display("FAIL basic_latency got=%0d want=%0d",
                     last_valid_cyc - start_cyc, 1000);
        end
        repeat (3) @(posedge ACLK);
        #1;
        vectors = vectors + 1;
        if (busy !== 1'b0 || valid_cnt !== v0 + 1) begin
            miscompares = miscompares + 1;
            $display("FAIL basic_after got busy=%b valids=%0d want busy=0 valids=%0d",
                     busy, valid_cnt - v0, 1);
        end
    endtask

    task automatic test_abort;
        int v0;
        v0 = valid_cnt;
        pulse_start(32'd1000);
        repeat (48) @(posedge ACLK);
        #1;
        en = 1'b0;
        @(posedge ACLK);
        #1;
        vectors = vectors + 1;
        if (busy !== 1'b0) begin
            miscompares = miscompares + 1;
            $display("FAIL abort_busy got=%b want=0", busy);
        end
        repeat (1100) @(posedge ACLK);
        #1;
        vectors = vectors + 1;
        if (valid_cnt !== v0 || edge_count !== 32'd100 || overflow !== 1'b0) begin
            miscompares = miscompares + 1;
            $display("FAIL abort_hold got valids=%0d cnt=%0d want valids=0 cnt=100",
                     valid_cnt - v0, edge_count);
        end
        en = 1'b1;
    endtask

    task automatic test_saturation;
        int v0;
        sig_period = 2;
        repeat (4) @(posedge ACLK);
        v0 = valid_cnt;
        push_both(32'd500, 1'b0, 32'd255, 1'b1);
        pulse_start(32'd1000);
        wait_valid(v0 + 1, 1100);
        push_both(32'd50, 1'b0, 32'd50, 1'b0);
        pulse_start(32'd100);
        wait_valid(v0 + 2, 200);
        vectors = vectors + 1;
        if (last_valid_cyc !== start_cyc + 100) begin
            miscompares = miscompares + 1;
            $display("FAIL sat_latency got=%0d want=%0d",
                     last_valid_cyc - start_cyc, 100);
        end
        sig_period = 10;
        repeat (4) @(posedge ACLK);
    endtask

    task automatic test_continuous;
        int v0;
        int t1;
        int t2;
        int t3;
        v0 = valid_cnt;
        continuous = 1'b1;
        push_both(32'd10, 1'b0, 32'd10, 1'b0);
        push_both(32'd10, 1'b0, 32'd10, 1'b0);
        push_both(32'd20, 1'b0, 32'd20, 1'b0);
        push_both(32'd20, 1'b0, 32'd20, 1'b0);
        pulse_start(32'd100);
        wait_valid(v0 + 1, 200);
        t1 = last_valid_cyc;
        vectors = vectors + 1;
        if (t1 !== start_cyc + 100) begin
            miscompares = miscompares + 1;
            $display("FAIL cont_first got=%0d want=%0d", t1 - start_cyc, 100);
        end
        repeat (50) @(posedge ACLK);
        #1;
        gate_len = 32'd200;
        wait_valid(v0 + 2, 200);
        t2 = last_valid_cyc;
        vectors = vectors + 1;
        if (t2 - t1 !== 101) begin
            miscompares = miscompares + 1;
            $display("FAIL cont_period1 got=%0d want=101", t2 - t1);
        end
        wait_valid(v0 + 3, 300);
        t3 = last_valid_cyc;
        vectors = vectors + 1;
        if (t3 - t2 !== 201) begin
            miscompares = miscompares + 1;
            $display("FAIL cont_period2 got=%0d want=201", t3 - t2);
        end
        continuous = 1'b0;
        wait_valid(v0 + 4, 300);
        vectors = vectors + 1;
        if (last_valid_cyc - t3 !== 201) begin
            miscompares = miscompares + 1;
            $display("FAIL cont_period3 got=%0d want=201", last_valid_cyc - t3);
        end
        repeat (3) @(posedge ACLK);
        #1;
        vectors = vectors + 1;
        if (busy !== 1'b0) begin
            miscompares = miscompares + 1;
            $display("FAIL cont_stop_busy got=%b want=0", busy);
        end
    endtask

    task automatic test_zero_and_restart;
        int v0;
        int busy_seen;
        v0 = valid_cnt;
        busy_seen = 0;
        pulse_start(32'd0);
        repeat (20) begin
            @(posedge ACLK);
            #1;
            if (busy) busy_seen = busy_seen + 1;
        end
        vectors = vectors + 1;
        if (busy_seen !== 0 || valid_cnt !== v0) begin
            miscompares = miscompares + 1;
            $display("FAIL zero_gate got busy_cycles=%0d valids=%0d want 0 0",
                     busy_seen, valid_cnt - v0);
        end
        push_both(32'd10, 1'b0, 32'd10, 1'b0);
        pulse_start(32'd100);
        repeat (30) @(posedge ACLK);
        #1;
        gate_len = 32'd50;
        start = 1'b1;
        @(posedge ACLK);
        #1;
        start = 1'b0;
        wait_valid(v0 + 1, 200);
        vectors = vectors + 1;
        if (last_valid_cyc !== start_cyc + 100) begin
            miscompares = miscompares + 1;
            $display("FAIL restart_ignored got=%0d want=%0d",
                     last_valid_cyc - start_cyc, 100);
        end
        repeat (20) @(posedge ACLK);
        #1;
        vectors = vectors + 1;
        if (valid_cnt !== v0 + 1 || busy !== 1'b0) begin
            miscompares = miscompares + 1;
            $display("FAIL restart_extra got valids=%0d busy=%b want 1 0",
                     valid_cnt - v0, busy);
        end
    endtask

    task automatic test_reset_mid_gate;
        int v0;
        v0 = valid_cnt;
        pulse_start(32'd1000);
        repeat (200) @(posedge ACLK);
        #1;
        ARESET = 1'b1;
        @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        vectors = vectors + 1;
        if ({edge_count, overflow, count_valid, busy} !== 35'd0) begin
            miscompares = miscompares + 1;
            $display("FAIL midreset got cnt=%0d ovf=%b vld=%b busy=%b want 0",
                     edge_count, overflow, count_valid, busy);
        end
        repeat (20) @(posedge ACLK);
        push_both(32'd10, 1'b0, 32'd10, 1'b0);
        pulse_start(32'd100);
        wait_valid(v0 + 1, 1200);
        vectors = vectors + 1;
        if (last_valid_cyc !== start_cyc + 100) begin
            miscompares = miscompares + 1;
            $display("FAIL midreset_latency got=%0d want=%0d",
                     last_valid_cyc - start_cyc, 100);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_abort();
        test_saturation();
        test_continuous();
        test_zero_and_restart();
        test_reset_mid_gate();
        repeat (5) @(posedge ACLK);
        #1;
        vectors = vectors + 1;
        if (q32.size() !== 0 || q8.size() !== 0) begin
            miscompares = miscompares + 1;
            $display("FAIL pending_results got q32=%0d q8=%0d want 0 0",
                     q32.size(), q8.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
